// File: rtl/console_cursor_ctrl.sv
// console_cursor_ctrl: turns a stream of ASCII codes into writes to a
// NUM_ROWS x NUM_COLS character buffer and tracks the cursor position.
// Handles printable characters, CR, LF, BS and FF (screen clear).
// Build option: define CONSOLE_SCROLL_EN to scroll the screen up one row
// when the cursor advances past the last row. Without it the cursor wraps
// to (0,0) and no scroll hardware is built.
module console_cursor_ctrl #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10,
  localparam int AW = $clog2(NUM_ROWS * NUM_COLS),
  localparam int RW = $clog2(NUM_ROWS),
  localparam int CW = $clog2(NUM_COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [6:0]    in_char,
  input  logic [1:0]    in_color,
  output logic          in_ready,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [8:0]    buf_wdata,
  output logic [AW-1:0] buf_raddr,
  input  logic [8:0]    buf_rdata,
  output logic [RW-1:0] cursor_row,
  output logic [CW-1:0] cursor_col,
  output logic          busy
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] CLEAR       = 2'd1;
`ifdef CONSOLE_SCROLL_EN
  localparam logic [1:0] SCROLL_COPY = 2'd2;
  localparam logic [1:0] SCROLL_FILL = 2'd3;

  localparam logic [AW-1:0] LAST_COPY = AW'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [AW-1:0] FILL_BASE = AW'((NUM_ROWS - 1) * NUM_COLS);
  localparam logic [AW-1:0] LAST_FILL = AW'(NUM_COLS - 1);
`endif

  localparam logic [8:0]    BLANK     = 9'h020;
  localparam logic [AW-1:0] LAST_CELL = AW'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(NUM_COLS - 1);

  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;

  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic          accept;
  logic          printable;
  logic          advance;
  logic [AW-1:0] cur_addr;

  // Characters are only taken while no clear/scroll sequence is running
  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;
  assign accept    = in_valid & in_ready;
  assign printable = (in_char >= 7'h20) && (in_char <= 7'h7E);
  // A printable in the last column or an LF moves to the start of the next line
  assign advance   = (printable && (cursor_col == LAST_COL)) || (in_char == CH_LF);
  assign cur_addr  = AW'(cursor_row) * AW'(NUM_COLS) + AW'(cursor_col);

`ifdef CONSOLE_SCROLL_EN
  // Scroll copy reads one row ahead of the address it writes
  assign buf_raddr = cnt + AW'(NUM_COLS);
`else
  logic [8:0] unused_rdata;
  assign unused_rdata = buf_rdata;
  assign buf_raddr    = '0;
`endif

  // Sequencer: character handling in IDLE, address walk for clear and scroll
  always_ff @(posedge clk) begin
    buf_we <= 1'b0;
    if (reset) begin
      state      <= CLEAR;
      cnt        <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              buf_we     <= 1'b1;
              buf_addr   <= cur_addr;
              buf_wdata  <= {in_color, in_char};
              cursor_col <= cursor_col + 1'b1;
            end else begin
              case (in_char)
                CH_CR: cursor_col <= '0;
                CH_BS: begin
                  if (cursor_col != '0) begin
                    cursor_col <= cursor_col - 1'b1;
                    buf_we     <= 1'b1;
                    buf_addr   <= cur_addr - AW'(1);
                    buf_wdata  <= BLANK;
                  end
                end
                CH_FF: begin
                  state      <= CLEAR;
                  cnt        <= '0;
                  cursor_row <= '0;
                  cursor_col <= '0;
                end
                default: ;
              endcase
            end
            // Later assignment overrides the column increment above on wrap
            if (advance) begin
              cursor_col <= '0;
              if (cursor_row != LAST_ROW) begin
                cursor_row <= cursor_row + 1'b1;
              end else begin
`ifdef CONSOLE_SCROLL_EN
                state <= SCROLL_COPY;
                cnt   <= '0;
`else
                cursor_row <= '0;
`endif
              end
            end
          end
        end
        CLEAR: begin
          buf_we    <= 1'b1;
          buf_addr  <= cnt;
          buf_wdata <= BLANK;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_CELL) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
`ifdef CONSOLE_SCROLL_EN
        SCROLL_COPY: begin
          buf_we    <= 1'b1;
          buf_addr  <= cnt;
          buf_wdata <= buf_rdata;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_COPY) begin
            state <= SCROLL_FILL;
            cnt   <= '0;
          end
        end
        SCROLL_FILL: begin
          buf_we    <= 1'b1;
          buf_addr  <= FILL_BASE + cnt;
          buf_wdata <= BLANK;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_FILL) begin
            state      <= IDLE;
            cnt        <= '0;
            cursor_row <= LAST_ROW;
            cursor_col <= '0;
          end
        end
`endif
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_cursor_ctrl.sv
// Self-checking bench for console_cursor_ctrl (3 rows x 10 columns).
// Buffer writes are matched in order against a queue of expected writes;
// cursor and handshake outputs are checked after each character.
module tb_console_cursor_ctrl;

  localparam int NR    = 3;
  localparam int NC    = 10;
  localparam int CELLS = NR * NC;
  localparam logic [8:0] BLANK = 9'h020;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [6:0] in_char;
  logic [1:0] in_color;
  logic       in_ready;
  logic       buf_we;
  logic [4:0] buf_addr;
  logic [8:0] buf_wdata;
  logic [4:0] buf_raddr;
  logic [8:0] buf_rdata;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;

  logic [8:0]  mem     [0:31];
  logic [8:0]  ref_mem [0:31];
  logic [13:0] exp_q   [$];
  logic [13:0] mon_e;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] ch;
    logic [1:0] co;
    bit         we;
    logic [4:0] a;
    logic [8:0] d;
    int         er;
    int         ec;
  } vec_t;
  vec_t vecs [15];

  always #5 clk = ~clk;

  console_cursor_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_color   (in_color),
    .in_ready   (in_ready),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .buf_raddr  (buf_raddr),
    .buf_rdata  (buf_rdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  // Character buffer: synchronous write, combinational read
  always @(posedge clk) if (buf_we) mem[buf_addr] <= buf_wdata;
  assign buf_rdata = mem[buf_raddr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [8:0] d);
    exp_q.push_back({a, d});
    ref_mem[a] = d;
  endtask

  // Scoreboard: every DUT write must match the oldest expected write
  always @(negedge clk) begin
    if (buf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual addr %0d data %0h required no write",
                 buf_addr, buf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", buf_addr, mon_e[13:9]);
        chk("write_data", buf_wdata, mon_e[8:0]);
      end
    end
  end

  // n = number of further cycles busy stayed high
  task automatic wait_idle(input string name, output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_idle"}, busy, 0);
    @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic send(input string name, input logic [6:0] ch, input logic [1:0] co,
                      input bit we, input logic [4:0] a, input logic [8:0] d,
                      input int er, input int ec);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (in_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_char  = ch;
    in_color = co;
    if (we) push_exp(a, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_we"}, buf_we, we);
    chk({name, "_row"}, cursor_row, er);
    chk({name, "_col"}, cursor_col, ec);
  endtask

  task automatic expect_scroll();
    for (int i = 0; i < (NR - 1) * NC; i++) push_exp(5'(i), ref_mem[i + NC]);
    for (int i = 0; i < NC; i++) push_exp(5'((NR - 1) * NC + i), BLANK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_char  = '0;
    in_color = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end

    vecs[0]  = '{7'h41, 2'd2, 1'b1, 5'd0,  9'h141, 0, 1};
    vecs[1]  = '{7'h42, 2'd1, 1'b1, 5'd1,  9'h0C2, 0, 2};
    vecs[2]  = '{7'h43, 2'd0, 1'b1, 5'd2,  9'h043, 0, 3};
    vecs[3]  = '{7'h08, 2'd3, 1'b1, 5'd2,  9'h020, 0, 2};
    vecs[4]  = '{7'h07, 2'd1, 1'b0, 5'd0,  9'h000, 0, 2};
    vecs[5]  = '{7'h7F, 2'd2, 1'b0, 5'd0,  9'h000, 0, 2};
    vecs[6]  = '{7'h0D, 2'd0, 1'b0, 5'd0,  9'h000, 0, 0};
    vecs[7]  = '{7'h08, 2'd0, 1'b0, 5'd0,  9'h000, 0, 0};
    vecs[8]  = '{7'h0A, 2'd0, 1'b0, 5'd0,  9'h000, 1, 0};
    vecs[9]  = '{7'h7E, 2'd3, 1'b1, 5'd10, 9'h1FE, 1, 1};
    vecs[10] = '{7'h20, 2'd1, 1'b1, 5'd11, 9'h0A0, 1, 2};
    vecs[11] = '{7'h1F, 2'd0, 1'b0, 5'd0,  9'h000, 1, 2};
    vecs[12] = '{7'h0A, 2'd0, 1'b0, 5'd0,  9'h000, 2, 0};
    vecs[13] = '{7'h7A, 2'd0, 1'b1, 5'd20, 9'h07A, 2, 1};
    vecs[14] = '{7'h0D, 2'd0, 1'b0, 5'd0,  9'h000, 2, 0};

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_we", buf_we, 0);
    chk("reset_ready", in_ready, 0);
    chk("reset_busy", busy, 1);
    chk("reset_row", cursor_row, 0);
    chk("reset_col", cursor_col, 0);

    // Power-up clear of all cells
    @(posedge clk); #1;
    for (int i = 0; i < CELLS; i++) push_exp(5'(i), BLANK);
    reset = 1'b0;
    wait_idle("init_clear", n);
    chk("init_row", cursor_row, 0);
    chk("init_col", cursor_col, 0);

    // Single characters and control codes
    for (int i = 0; i < 15; i++)
      send($sformatf("vec%0d", i), vecs[i].ch, vecs[i].co, vecs[i].we,
           vecs[i].a, vecs[i].d, vecs[i].er, vecs[i].ec);

    // Form feed from the middle of the screen
    send("ff", 7'h0C, 2'd0, 1'b0, 5'd0, 9'h000, 0, 0);
    for (int i = 0; i < CELLS; i++) push_exp(5'(i), BLANK);
    wait_idle("ff_clear", n);

    // Ten printables with in_valid held: one accepted per cycle
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("b2b_ready%0d", k), in_ready, 1);
      in_valid = 1'b1;
      in_char  = 7'(97 + k);
      in_color = k[1:0];
      push_exp(5'(k), {k[1:0], 7'(97 + k)});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_row", cursor_row, 1);
    chk("b2b_col", cursor_col, 0);

    // Move to (2,4)
    send("lf_to_r2", 7'h0A, 2'd0, 1'b0, 5'd0, 9'h000, 2, 0);
    for (int k = 0; k < 4; k++)
      send($sformatf("r2_%0d", k), 7'(8'h30 + k), 2'd1, 1'b1, 5'(20 + k),
           9'(9'h0B0 + k), 2, k + 1);

    // LF on the last row
`ifdef CONSOLE_SCROLL_EN
    send("lf_scroll", 7'h0A, 2'd0, 1'b0, 5'd0, 9'h000, 2, 0);
    expect_scroll();
    wait_idle("lf_scroll", n);
    // send already observed the first busy cycle
    chk("lf_scroll_busy_ge30", int'(n + 1 >= 30), 1);
    chk("lf_scroll_row", cursor_row, 2);
    chk("lf_scroll_col", cursor_col, 0);
`else
    send("lf_wrap", 7'h0A, 2'd0, 1'b0, 5'd0, 9'h000, 0, 0);
    chk("lf_wrap_ready", in_ready, 1);
    send("lf_r1", 7'h0A, 2'd0, 1'b0, 5'd0, 9'h000, 1, 0);
    send("lf_r2", 7'h0A, 2'd0, 1'b0, 5'd0, 9'h000, 2, 0);
`endif

    // Fill last row to column 9, then a printable in the final cell
    for (int k = 0; k < 9; k++)
      send($sformatf("fill_%0d", k), 7'(8'h4B + k), 2'd0, 1'b1, 5'(20 + k),
           9'(9'h04B + k), 2, k + 1);
`ifdef CONSOLE_SCROLL_EN
    send("last_cell", 7'h5A, 2'd3, 1'b1, 5'd29, 9'h1DA, 2, 0);
    expect_scroll();
    wait_idle("last_cell_scroll", n);
    chk("last_cell_row", cursor_row, 2);
    chk("last_cell_col", cursor_col, 0);
`else
    send("last_cell", 7'h5A, 2'd3, 1'b1, 5'd29, 9'h1DA, 0, 0);
    chk("last_cell_ready", in_ready, 1);
`endif

    // Form feed interrupted by reset: clear restarts from address 0
    send("ff2", 7'h0C, 2'd0, 1'b0, 5'd0, 9'h000, 0, 0);
    for (int i = 0; i < CELLS; i++) push_exp(5'(i), BLANK);
    n = 0;
    while (exp_q.size() > CELLS - 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("ff2_progress", int'(exp_q.size() <= CELLS - 5), 1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_we", buf_we, 0);
    chk("abort_busy", busy, 1);
    chk("abort_ready", in_ready, 0);
    chk("abort_row", cursor_row, 0);
    chk("abort_col", cursor_col, 0);
    @(posedge clk); #1;
    for (int i = 0; i < CELLS; i++) push_exp(5'(i), BLANK);
    reset = 1'b0;
    wait_idle("restart_clear", n);
    chk("restart_row", cursor_row, 0);
    chk("restart_col", cursor_col, 0);

    repeat (3) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_cursor_ctrl.md
CONSOLE_CURSOR_CTRL -- requirements
Module: console_cursor_ctrl

Interface
REQ-001: Parameter NUM_ROWS, default 3, text rows in the character buffer.
REQ-002: Parameter NUM_COLS, default 10, text columns per row; buffer address = row*NUM_COLS + col; AW = clog2(NUM_ROWS*NUM_COLS), RW = clog2(NUM_ROWS), CW = clog2(NUM_COLS).
REQ-003: clk  input  1  sole clock; all state changes on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: in_valid  input  1  character available.
REQ-006: in_char  input  7  ASCII code.
REQ-007: in_color  input  2  color bits for printable characters.
REQ-008: in_ready  output  1  controller accepts in_char this cycle.
REQ-009: buf_we  output  1  text-buffer write strobe, registered.
REQ-010: buf_addr  output  AW  write address, registered.
REQ-011: buf_wdata  output  9  {color[1:0], code[6:0]}, registered.
REQ-012: buf_raddr  output  AW  read address for scroll copy; buffer returns buf_rdata combinationally in the same cycle.
REQ-013: buf_rdata  input  9  buffer read data.
REQ-014: cursor_row  output  RW, cursor_col  output  CW  current cursor position.
REQ-015: busy  output  1  high in any state other than IDLE.

Function
REQ-016: The FSM SHALL have states IDLE, CLEAR, SCROLL_COPY and SCROLL_FILL; in_ready = 1 only in IDLE.
REQ-017: A character is accepted on a cycle with in_valid & in_ready; no other cycle changes the cursor.
REQ-018: Printable (0x20-0x7E): buf_we=1, buf_addr=cursor, buf_wdata={in_color,in_char} on the cycle after acceptance; cursor_col+1; at col NUM_COLS-1, line advance instead (REQ-021). Sustains one printable per cycle.
REQ-019: 0x0D (CR): col=0, no write. 0x08 (BS): if col>0, col-1 and write {00,0x20} at the new position; at col 0, no-op.
REQ-020: 0x0C (FF): enter CLEAR; write {00,0x20} to addresses 0..NUM_ROWS*NUM_COLS-1, one per cycle, ascending; cursor to (0,0); return to IDLE after the last write.
REQ-021: 0x0A (LF) and line advance: col=0; row<NUM_ROWS-1 -> row+1; row=NUM_ROWS-1 -> end-of-screen behaviour (REQ-028).
REQ-022: All other codes (0x00-0x1F not listed above, 0x7F) SHALL be accepted and ignored.
REQ-023: SCROLL_COPY: for i = 0..(NUM_ROWS-1)*NUM_COLS-1 ascending, buf_raddr=i+NUM_COLS in cycle k; buf_wdata=buf_rdata captured, buf_addr=i, buf_we=1 in cycle k+1.
REQ-024: SCROLL_FILL: write {00,0x20} to the last row, cols 0..NUM_COLS-1 ascending, then IDLE with cursor (NUM_ROWS-1, 0).
REQ-025: A printable write that triggers a scroll SHALL be issued before the first copy write; writes never overlap (one buf_we per cycle).
REQ-026: buf_we SHALL be 0 in every cycle not listed above; buf_raddr is don't-care outside SCROLL_COPY.

Reset
REQ-027: reset SHALL force CLEAR with counter 0, cursor (0,0), buf_we=0, in_ready=0, busy=1, aborting any scroll/clear in progress; the screen is cleared as in REQ-020 after reset deasserts.

Configuration
REQ-028: Macro CONSOLE_SCROLL_EN: defined -> line advance on the last row runs SCROLL_COPY then SCROLL_FILL; undefined -> cursor wraps to (0,0) with no buffer writes, the SCROLL states are not compiled, and in_ready stays 1 through the wrap.

Verification
REQ-029: Reset, then idle -> 30 writes of 0x020 to addresses 0..29 ascending, busy low afterward, cursor (0,0).
REQ-030: Send 'A'(0x41) color 2'b10 -> next cycle buf_we=1, addr 0, wdata 9'h141; cursor (0,1).
REQ-031: 10 printables back-to-back, in_valid held -> one accepted per cycle, addresses 0..9, cursor (1,0).
REQ-032: At col 0 send BS -> no write, cursor unchanged; at col 3 send BS -> write 0x020 at addr 2, cursor (0,2).
REQ-033: With CONSOLE_SCROLL_EN, cursor (2,4), send LF -> 20 copy writes (addr i <- old i+10), 10 fill writes at 20..29, in_ready low for 30+ cycles, cursor (2,0).
REQ-034: Without CONSOLE_SCROLL_EN, same stimulus -> no writes, cursor (0,0); FF mid-operation then reset -> clear restarts from address 0.
